// File: rtl/pic_pkg.sv
// Shared constants and ring-priority helpers for the PIC
// request/in-service stage.
package pic_pkg;

  localparam int NUM_IR = 8;

  typedef logic [NUM_IR-1:0] ir_vec_t;
  typedef logic [2:0]        ir_idx_t;

  function automatic ir_vec_t rotl(
    input ir_vec_t v,
    input ir_idx_t n
  );
    logic [2*NUM_IR-1:0] w;
    w = {v, v} << n;
    return w[2*NUM_IR-1:NUM_IR];
  endfunction

  function automatic ir_vec_t rotr(
    input ir_vec_t v,
    input ir_idx_t n
  );
    logic [2*NUM_IR-1:0] w;
    w = {v, v} >> n;
    return w[NUM_IR-1:0];
  endfunction

  function automatic ir_vec_t lsb_onehot(
    input ir_vec_t v
  );
    return v & (~v + ir_vec_t'(1));
  endfunction

  function automatic ir_idx_t onehot_idx(
    input ir_vec_t v
  );
    ir_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_IR; i++) begin
      if (v[i]) idx = idx | ir_idx_t'(i);
    end
    return idx;
  endfunction

  // rank 0 is the IR just above the rotate point
  function automatic ir_idx_t rank(
    input ir_vec_t oh,
    input ir_idx_t rot
  );
    ir_idx_t r;
    r = onehot_idx(oh) - rot - 3'd1;
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Picks the highest-priority set bit of a vector on the
// rotating ring, returned one-hot.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] vector,
  input  logic [2:0] rotate,
  output logic [7:0] onehot
);

  ir_idx_t shamt;
  ir_vec_t aligned;

  // align top priority to bit 0, take lowest set, rotate back
  always_comb begin
    shamt   = rotate + 3'd1;
    aligned = rotr(vector, shamt);
    onehot  = rotl(lsb_onehot(aligned), shamt);
  end

endmodule

// File: rtl/pic_irq_priority.sv
// 8259 IRR / ISR stage: sync, request latch, priority
// resolution, INT generation and INTA sequencing.
module pic_irq_priority
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ir_in,
  input  logic       init_clear,
  input  logic       level_edge_triggered,
  input  logic [7:0] int_mask,
  input  logic [7:0] clear_irr,
  input  logic [7:0] eoi,
  input  logic [2:0] priority_rotate,
  input  logic       auto_eoi,
  input  logic       ack_first,
  input  logic       ack_second,
  output logic       int_req,
  output logic [7:0] irr,
  output logic [7:0] in_service_reg,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] acknowledge_interrupt,
  output logic [2:0] ack_vector_id,
  output logic       ack_active
);

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  ir_vec_t sync_ir;
  ir_vec_t prev_q, prev_d;
  ir_vec_t irr_q, irr_d;
  ir_vec_t isr_q, isr_d;
  ir_vec_t ack_q, ack_d;
  logic    act_q, act_d;
  logic    spur_q, spur_d;
  logic    int_q, int_d;

  ir_vec_t req;
  ir_vec_t cand;
  ir_vec_t isr_top;
  ir_vec_t rise;
  ir_vec_t grant_mask;
  logic    grant;
  logic    finish;
  logic    preempt;

  assign sync_ir = sync_q[SYNC_STAGES-1];
  assign req     = irr_q & ~int_mask;

  pic_priority_resolver u_req_res (
    .vector (req),
    .rotate (priority_rotate),
    .onehot (cand)
  );

  pic_priority_resolver u_isr_res (
    .vector (isr_q),
    .rotate (priority_rotate),
    .onehot (isr_top)
  );

  // next-state for sync chain, IRR, ISR, INTA sequence and INT
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ir_in};
    grant      = ack_first & ~act_q;
    finish     = ack_second & act_q;
    rise       = sync_ir & ~prev_q;
    grant_mask = grant ? cand : '0;
    prev_d     = sync_ir;
    ack_d      = ack_q;
    act_d      = act_q;
    spur_d     = spur_q;

    if (level_edge_triggered) begin
      irr_d = sync_ir & ~clear_irr;
    end else begin
      irr_d = (irr_q | rise) & ~clear_irr & ~grant_mask;
    end

    isr_d = isr_q & ~eoi;

    if (grant) begin
      act_d = 1'b1;
      unique case (1'b1)
        (cand != '0): begin
          isr_d  = isr_d | cand;
          ack_d  = cand;
          spur_d = 1'b0;
        end
        default: begin
          ack_d  = 8'h80;
          spur_d = 1'b1;
        end
      endcase
    end

    if (finish) begin
      act_d = 1'b0;
      if (auto_eoi && !spur_q) isr_d = isr_d & ~ack_q;
    end

    preempt = (isr_q == '0) ||
              (rank(cand, priority_rotate) <
               rank(isr_top, priority_rotate));
    int_d   = !act_d && (cand != '0) && preempt;

    if (init_clear) begin
      irr_d  = '0;
      isr_d  = '0;
      ack_d  = '0;
      act_d  = 1'b0;
      spur_d = 1'b0;
      prev_d = '0;
      int_d  = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      irr_q  <= '0;
      isr_q  <= '0;
      ack_q  <= '0;
      act_q  <= 1'b0;
      spur_q <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      irr_q  <= irr_d;
      isr_q  <= isr_d;
      ack_q  <= ack_d;
      act_q  <= act_d;
      spur_q <= spur_d;
      int_q  <= int_d;
    end
  end

  assign int_req                  = int_q;
  assign irr                      = irr_q;
  assign in_service_reg           = isr_q;
  assign highest_level_in_service = isr_top;
  assign acknowledge_interrupt    = ack_q;
  assign ack_vector_id            = onehot_idx(ack_q);
  assign ack_active               = act_q;

endmodule

// File: tb/tb_pic_irq_priority.sv
// Directed bench for pic_irq_priority with a cycle model
// and literal spot checks.
module tb_pic_irq_priority;

  localparam int SYNC = 2;

  logic       clk;
  logic       reset_n;
  logic [7:0] ir_in;
  logic       init_clear;
  logic       level_edge_triggered;
  logic [7:0] int_mask;
  logic [7:0] clear_irr;
  logic [7:0] eoi;
  logic [2:0] priority_rotate;
  logic       auto_eoi;
  logic       ack_first;
  logic       ack_second;
  logic       int_req;
  logic [7:0] irr;
  logic [7:0] in_service_reg;
  logic [7:0] highest_level_in_service;
  logic [7:0] acknowledge_interrupt;
  logic [2:0] ack_vector_id;
  logic       ack_active;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_sync [SYNC];
  logic [7:0] m_prev, m_irr, m_isr, m_ack;
  logic       m_act, m_spur, m_int;

  pic_irq_priority #(.SYNC_STAGES(SYNC)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .ir_in                    (ir_in),
    .init_clear               (init_clear),
    .level_edge_triggered     (level_edge_triggered),
    .int_mask                 (int_mask),
    .clear_irr                (clear_irr),
    .eoi                      (eoi),
    .priority_rotate          (priority_rotate),
    .auto_eoi                 (auto_eoi),
    .ack_first                (ack_first),
    .ack_second               (ack_second),
    .int_req                  (int_req),
    .irr                      (irr),
    .in_service_reg           (in_service_reg),
    .highest_level_in_service (highest_level_in_service),
    .acknowledge_interrupt    (acknowledge_interrupt),
    .ack_vector_id            (ack_vector_id),
    .ack_active               (ack_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] v,
                              input logic [2:0] r);
    int i;
    for (int k = 0; k < 8; k++) begin
      i = (int'(r) + 1 + k) % 8;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int rank_of(input int i,
                                 input logic [2:0] r);
    return (i - int'(r) - 1 + 16) % 8;
  endfunction

  function automatic logic [2:0] idx_of(input logic [7:0] v);
    logic [2:0] id;
    id = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) id = 3'(i);
    return id;
  endfunction

  // behavioural model, advanced once per clock
  initial begin : model
    logic [7:0] raw, n_irr, n_isr, n_ack;
    logic       n_act, n_spur, grant;
    int         c, t;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int s = 0; s < SYNC; s++) m_sync[s] = '0;
        m_prev = '0; m_irr = '0; m_isr = '0; m_ack = '0;
        m_act = 1'b0; m_spur = 1'b0; m_int = 1'b0;
      end else begin
        raw   = m_sync[SYNC-1];
        c     = pick(m_irr & ~int_mask, priority_rotate);
        t     = pick(m_isr, priority_rotate);
        grant = ack_first && !m_act;
        n_ack = m_ack; n_act = m_act; n_spur = m_spur;
        for (int i = 0; i < 8; i++) begin
          if (level_edge_triggered)
            n_irr[i] = raw[i] && !clear_irr[i];
          else if (clear_irr[i] || (grant && c == i))
            n_irr[i] = 1'b0;
          else if (raw[i] && !m_prev[i])
            n_irr[i] = 1'b1;
          else
            n_irr[i] = m_irr[i];
        end
        n_isr = m_isr & ~eoi;
        if (grant) begin
          n_act = 1'b1;
          if (c >= 0) begin
            n_isr[c] = 1'b1;
            n_ack = 8'h01 << c;
            n_spur = 1'b0;
          end else begin
            n_ack = 8'h80;
            n_spur = 1'b1;
          end
        end
        if (ack_second && m_act) begin
          n_act = 1'b0;
          if (auto_eoi && !m_spur) n_isr = n_isr & ~m_ack;
        end
        m_int = !n_act && (c >= 0) &&
                ((t < 0) ||
                 (rank_of(c, priority_rotate) <
                  rank_of(t, priority_rotate)));
        m_prev = raw;
        if (init_clear) begin
          n_irr = '0; n_isr = '0; n_ack = '0;
          n_act = 1'b0; n_spur = 1'b0;
          m_int = 1'b0; m_prev = '0;
        end
        m_irr = n_irr; m_isr = n_isr; m_ack = n_ack;
        m_act = n_act; m_spur = n_spur;
        for (int s = SYNC - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
        m_sync[0] = ir_in;
      end
    end
  end

  // per-cycle comparison against the model
  initial begin : compare
    logic [7:0] top;
    int t;
    forever begin
      @(negedge clk);
      t   = pick(m_isr, priority_rotate);
      top = (t < 0) ? 8'h00 : (8'h01 << t);
      check("m_irr", irr, m_irr);
      check("m_isr", in_service_reg, m_isr);
      check("m_top", highest_level_in_service, top);
      check("m_ack", acknowledge_interrupt, m_ack);
      check("m_id", 8'(ack_vector_id), 8'(idx_of(m_ack)));
      check("m_act", 8'(ack_active), 8'(m_act));
      check("m_int", 8'(int_req), 8'(m_int));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_ir(input logic [7:0] v);
    ir_in = v;
    step();
    ir_in = '0;
  endtask

  task automatic do_ack();
    ack_first = 1'b1;
    step();
    ack_first = 1'b0;
  endtask

  task automatic do_fin();
    ack_second = 1'b1;
    step();
    ack_second = 1'b0;
  endtask

  task automatic do_eoi(input logic [7:0] v);
    eoi = v;
    step();
    eoi = '0;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_int"}, 8'(int_req), 8'h00);
    check({tag, "_irr"}, irr, 8'h00);
    check({tag, "_isr"}, in_service_reg, 8'h00);
    check({tag, "_top"}, highest_level_in_service, 8'h00);
    check({tag, "_ack"}, acknowledge_interrupt, 8'h00);
    check({tag, "_id"}, 8'(ack_vector_id), 8'h00);
    check({tag, "_act"}, 8'(ack_active), 8'h00);
  endtask

  initial begin : stim
    reset_n = 1'b1;
    ir_in = '0; init_clear = 1'b0;
    level_edge_triggered = 1'b0;
    int_mask = '0; clear_irr = '0; eoi = '0;
    priority_rotate = 3'd7; auto_eoi = 1'b0;
    ack_first = 1'b0; ack_second = 1'b0;
    #1 reset_n = 1'b0;
    steps(3);
    all_zero("rst");
    reset_n = 1'b1;
    init_clear = 1'b1;
    step();
    init_clear = 1'b0;
    step();

    // single edge request, latency and full INTA
    pulse_ir(8'h08);
    step();
    check("lat_irr_e2", irr, 8'h00);
    step();
    check("lat_irr_e3", irr, 8'h08);
    check("lat_int_e3", 8'(int_req), 8'h00);
    step();
    check("lat_int_e4", 8'(int_req), 8'h01);
    do_ack();
    check("t1_isr", in_service_reg, 8'h08);
    check("t1_irr", irr, 8'h00);
    check("t1_id", 8'(ack_vector_id), 8'h03);
    check("t1_int", 8'(int_req), 8'h00);
    do_fin();
    check("t1_act", 8'(ack_active), 8'h00);
    check("t1_hold", acknowledge_interrupt, 8'h08);
    do_eoi(8'h08);
    check("t1_eoi", in_service_reg, 8'h00);

    // simultaneous IR2+IR5 under two rotations
    pulse_ir(8'h24);
    steps(3);
    do_ack();
    check("r7_id", 8'(ack_vector_id), 8'h02);
    do_fin();
    do_eoi(8'h04);
    step();
    do_ack();
    check("r7_id2", 8'(ack_vector_id), 8'h05);
    do_fin();
    do_eoi(8'h20);
    priority_rotate = 3'd2;
    pulse_ir(8'h24);
    steps(3);
    do_ack();
    check("r2_id", 8'(ack_vector_id), 8'h05);
    check("r2_isr", in_service_reg, 8'h20);
    do_fin();
    do_eoi(8'h20);
    clear_irr = 8'h04;
    step();
    clear_irr = '0;
    check("r2_clr", irr, 8'h00);
    priority_rotate = 3'd7;

    // nesting under IR4 in service
    pulse_ir(8'h10);
    steps(3);
    do_ack();
    do_fin();
    check("n_isr4", in_service_reg, 8'h10);
    pulse_ir(8'h40);
    steps(3);
    check("n_irr6", irr, 8'h40);
    check("n_int6", 8'(int_req), 8'h00);
    pulse_ir(8'h02);
    steps(3);
    check("n_int1", 8'(int_req), 8'h01);
    do_ack();
    check("n_isr", in_service_reg, 8'h12);
    check("n_top", highest_level_in_service, 8'h02);
    do_fin();
    eoi = 8'h12;
    clear_irr = 8'h40;
    step();
    eoi = '0;
    clear_irr = '0;
    step();

    // level mode with auto EOI
    level_edge_triggered = 1'b1;
    auto_eoi = 1'b1;
    ir_in = 8'h01;
    steps(4);
    check("lv_irr", irr, 8'h01);
    check("lv_int", 8'(int_req), 8'h01);
    do_ack();
    check("lv_isr", in_service_reg, 8'h01);
    do_fin();
    check("lv_aeoi", in_service_reg, 8'h00);
    check("lv_irr2", irr, 8'h01);
    step();
    check("lv_reint", 8'(int_req), 8'h01);
    ir_in = '0;
    steps(5);
    level_edge_triggered = 1'b0;
    auto_eoi = 1'b0;
    check("lv_off", irr, 8'h00);

    // mask withdraws request, spurious ack
    pulse_ir(8'h20);
    steps(3);
    check("sp_int", 8'(int_req), 8'h01);
    int_mask = 8'h20;
    step();
    check("sp_drop", 8'(int_req), 8'h00);
    do_ack();
    check("sp_ack", acknowledge_interrupt, 8'h80);
    check("sp_id", 8'(ack_vector_id), 8'h07);
    check("sp_isr", in_service_reg, 8'h00);
    check("sp_irr", irr, 8'h20);
    do_fin();
    clear_irr = 8'h20;
    step();
    clear_irr = '0;
    int_mask = '0;
    step();

    // reset in the middle of an acknowledge
    pulse_ir(8'h08);
    steps(3);
    do_ack();
    check("mr_act", 8'(ack_active), 8'h01);
    reset_n = 1'b0;
    #1;
    all_zero("mr");
    steps(2);
    reset_n = 1'b1;
    step();

    // eoi and grant of the same bit in one cycle
    pulse_ir(8'h08);
    steps(3);
    ack_first = 1'b1;
    eoi = 8'h08;
    step();
    ack_first = 1'b0;
    eoi = '0;
    check("se_isr", in_service_reg, 8'h08);
    init_clear = 1'b1;
    step();
    init_clear = 1'b0;
    check("ic_isr", in_service_reg, 8'h00);
    check("ic_act", 8'(ack_active), 8'h00);
    check("ic_ack", acknowledge_interrupt, 8'h00);
    steps(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
